// File: rtl/ps2_scancode_rx.sv
// PS/2 set-2 receiver: filters the raw lines and folds E0/F0 prefixes into key events.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not check.
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PAR_CHECK = 1'b1;
`else
    localparam logic PAR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t     state, state_n;
    logic       clk_s1, clk_s2, dat_s1, dat_s2;
    logic       clk_f, clk_fq;
    logic [FLT_W-1:0] flt_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic       sample, tmo_hit;
    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] shreg, shreg_n;
    logic       par_bit, par_n;
    logic       par_ok;
    logic       byte_valid, byte_valid_n;
    logic       frame_err_n;
    logic       ext_flag, brk_flag;
    logic [2:0] skip_cnt;
    logic       is_e0, is_f0, is_e1, is_drop;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            clk_f   <= 1'b1;
            clk_fq  <= 1'b1;
            flt_cnt <= '0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            clk_fq <= clk_f;
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    assign sample  = clk_fq & ~clk_f;
    // A sample event in the same cycle wins over the timeout.
    assign tmo_hit = (state != IDLE) && !sample &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign par_ok  = (^{shreg, par_bit}) | ~PAR_CHECK;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (sample || state == IDLE || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            par_bit    <= par_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bitcnt_n     = bitcnt;
        shreg_n      = shreg;
        par_n        = par_bit;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        if (sample) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n  = DATA;
                        bitcnt_n = 3'd0;
                    end
                end
                DATA: begin
                    shreg_n  = {dat_s2, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    if (dat_s2 && par_ok) byte_valid_n = 1'b1;
                    else                  frame_err_n  = 1'b1;
                end
            endcase
        end else if (tmo_hit) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
        end
    end

    assign is_e0   = (shreg == 8'hE0);
    assign is_f0   = (shreg == 8'hF0);
    assign is_e1   = (shreg == 8'hE1);
    assign is_drop = (shreg inside {8'hAA, 8'hFA, 8'hEE,
                                    8'hFC, 8'h00, 8'hFF});

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            skip_cnt     <= 3'd0;
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= 8'h00;
        end else begin
            key_strobe <= 1'b0;
            if (tmo_hit) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else begin
                    unique case (1'b1)
                        is_e0: ext_flag <= 1'b1;
                        is_f0: brk_flag <= 1'b1;
                        is_e1: begin
                            skip_cnt <= 3'd7;
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                        is_drop: begin
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                        default: begin
                            key_strobe   <= 1'b1;
                            key_code     <= shreg;
                            key_extended <= ext_flag;
                            key_pressed  <= ~brk_flag;
                            ext_flag     <= 1'b0;
                            brk_flag     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Deserialises the raw PS/2 keyboard clock/data lines into set-2 scancode bytes.
- Folds E0 (extended) and F0 (break) prefixes into flags.
- Emits one qualified key event per key action on the key_strobe / key_pressed / key_extended / key_code interface.
- Sits directly upstream of the Oric keyboard matrix block and feeds those four ports unchanged.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk may change.
- TIMEOUT_CYC, 50000: clk_sys cycles without a sample event before a partial frame is abandoned.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from the pin (asynchronous).
- ps2_data  in  1  raw PS/2 data from the pin (asynchronous).
- key_strobe  out  1  one-cycle pulse; a key event is valid on the outputs below.
- key_pressed  out  1  1 = make, 0 = break.
- key_extended  out  1  1 = event was prefixed by E0.
- key_code  out  8  scancode byte with prefixes removed.
- frame_err  out  1  one-cycle pulse on a framing error, parity error or timeout.

Behaviour:
- Reset (async, active-high) state:
  - all outputs 0.
  - FSM in IDLE; ext_flag, brk_flag and skip_cnt cleared.
  - synchronisers and filtered clock set to 1.
  - timeout counter 0.
- Synchronisation:
  - two-flop synchroniser on each of ps2_clk and ps2_data.
  - filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples.
- Sample event: a registered 1->0 transition of the filtered clock. The synchronised data is sampled in the same cycle.
- Frame FSM (acts on sample events only):
  - IDLE: data=0 (start bit) -> DATA with bitcnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: if data=1 and parity is good, pulse byte_valid for 1 cycle. Otherwise pulse frame_err. Return to IDLE either way.
- Timeout:
  - counter clears on every sample event and while in IDLE, and increments otherwise.
  - on reaching TIMEOUT_CYC-1 outside IDLE: FSM -> IDLE, frame_err pulses, ext_flag/brk_flag cleared, partial byte discarded.
- Prefix decode on byte_valid:
  - E0: set ext_flag; no strobe.
  - F0: set brk_flag; no strobe.
  - E1: load skip_cnt=7; this byte and the next 7 valid bytes (Pause sequence) are dropped with no strobe; flags cleared.
  - AA, FA, EE, FC, 00, FF: dropped; flags cleared; no strobe.
  - Any other byte:
    - next cycle: key_strobe=1, key_code=byte, key_extended=ext_flag, key_pressed=~brk_flag.
    - both flags cleared in that same cycle.
- Outputs:
  - key_code, key_extended and key_pressed are registered and change only in the strobe cycle; they hold until the next strobe.
  - latency: byte_valid at sample event cycle N+1, key_strobe at N+2, where N is the cycle the stop-bit sample event is registered.
- Simultaneous events: a timeout and a sample event in the same cycle resolve to the sample event; the timeout is ignored.
- key_strobe is never high for two consecutive cycles.
- Reset mid-frame: all state is lost; a prefix received before reset does not affect the first byte after reset.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: STOP requires odd parity over the 8 data bits plus the parity bit. A mismatch drops the byte and pulses frame_err.
- Undefined:
  - the parity bit is captured but ignored.
  - only a bad stop bit or a timeout raises frame_err.
  - a byte with wrong parity is decoded normally.

Test Plan:
- Frame 1C (parity 0, stop 1) -> exactly one key_strobe; key_code=8'h1C, key_pressed=1, key_extended=0; frame_err stays 0.
- Frames F0, 1C -> one strobe only, after 1C; key_code=8'h1C, key_pressed=0, key_extended=0.
- Frames E0, F0, 75 -> one strobe; key_code=8'h75, key_pressed=0, key_extended=1. A following 1C gives key_extended=0, key_pressed=1.
- Frame 1C with parity bit inverted:
  - macro defined -> frame_err pulse, no strobe.
  - macro undefined -> strobe with key_code=8'h1C.
- Start bit plus 4 data bits, then idle for TIMEOUT_CYC+10 cycles -> one frame_err pulse, FSM in IDLE. The next full 1C frame decodes correctly.
- Glitch tests:
  - a ps2_clk low glitch of FILTER_LEN-2 cycles mid-frame -> no extra bit shifted; the byte decodes correctly.
  - reset asserted after an E0 prefix, then frame 75 -> key_extended=0.
